msg_arbiter: RTL and testbench
==============================

# msg_arbiter

Round-robin scheduler that shares the single 32-bit message FIFO in the image processor between `NUM_CH` detector channels, e.g. red/green/blue box detectors. Each channel presents a latched three-word bounding-box message and holds a request. The arbiter selects one channel and checks FIFO headroom. It then writes ID, top-left and bottom-right words on consecutive cycles and acknowledges the channel. It sits between the per-colour bound trackers and the FIFO write port, replacing the single-source message-writer state machine.

## Interface
Parameters:
- `NUM_CH`, 4 — number of requesting channels (2..8).
- `FIFO_DEPTH`, 256 — FIFO capacity in words.
- `MSG_WORDS`, 3 — words per message; fixed, not overridable.

Ports:
- `clk`  in  1  — system clock.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `enable`  in  1  — when low, no new grant is issued; an in-flight message completes.
- `flush`  in  1  — synchronous abort; same-cycle pulse as the FIFO `sclr`.
- `req`  in  `NUM_CH`  — per-channel request; level, held until `ack`.
- `ch_id`  in  `NUM_CH*32`  — per-channel message ID word, e.g. "RBB".
- `ch_min`  in  `NUM_CH*22`  — per-channel {x_min[10:0], y_min[10:0]}.
- `ch_max`  in  `NUM_CH*22`  — per-channel {x_max[10:0], y_max[10:0]}.
- `ack`  out  `NUM_CH`  — one-cycle pulse to the served channel.
- `fifo_usedw`  in  8  — FIFO fill level.
- `fifo_wrreq`  out  1  — FIFO write strobe.
- `fifo_data`  out  32  — FIFO write word.
- `busy`  out  1  — high whenever state ≠ IDLE.
- `grant_ch`  out  3  — index of the current or last granted channel.

## Operation
State machine:
- States: IDLE → W_ID → W_MIN → W_MAX → IDLE.
- IDLE → W_ID when `enable & |req & (fifo_usedw <= FIFO_DEPTH-4) & ~flush`.
- On that transition, the winner is selected by rotating priority starting at `last+1` mod `NUM_CH`. Its `ch_id`, `ch_min` and `ch_max` are captured into internal registers, and `grant_ch` is updated.
- W_ID: `fifo_wrreq=1`, `fifo_data` = captured ID.
- W_MIN: `fifo_wrreq=1`, `fifo_data = {5'b0, x_min, 5'b0, y_min}`.
- W_MAX: `fifo_wrreq=1`, `fifo_data = {5'b0, x_max, 5'b0, y_max}`. `ack[grant_ch]=1` and `last <= grant_ch` on this cycle.
- `fifo_wrreq` and `ack` are decoded from state only. `fifo_data` is 0 in IDLE.

Boundary conditions:
- `flush` in any state: return to IDLE next cycle with no `ack`. The channel keeps `req` high and its message is retried in full. `last` is unchanged.
- `enable` dropping mid-message has no effect until the return to IDLE.
- Headroom is checked only in IDLE. The three writes are then guaranteed because the check reserves four words.
- A request deasserted before grant is simply never served.
- Payload changes after grant are ignored because the payload is captured.
- After the `ack` cycle, the served channel's `req` is ignored for one cycle. The requester's `req` deassert may lag `ack` by one cycle, and this prevents a double send.

## Timing
- Reset values: state IDLE, `last = NUM_CH-1` (so channel 0 has first priority), `ack=0`, `fifo_wrreq=0`, `fifo_data=0`, `busy=0`, `grant_ch=0`.
- Latency:
  - `req` seen in cycle N produces writes in N+1, N+2 and N+3, with `ack` in N+3.
  - Earliest next grant is decided in N+4 (IDLE), with its first write in N+5.
  - One message takes 4 cycles including IDLE, giving peak throughput of 3 words per 4 cycles.
- Fairness: with all channels requesting continuously, each channel is served exactly once every `NUM_CH` messages.

## Structure
- Shared package `imgproc_pkg`:
  - state enum (IDLE, W_ID, W_MIN, W_MAX)
  - `MSG_WORDS = 3`
  - coordinate width 11
  - packing function for `{5'b0, x, 5'b0, y}`
- Sub-module `rr_pick`: combinational rotating-priority encoder (`req`, `last`) → (`valid`, `idx`). It is reused by later arbiters.

## Test plan
- Single channel: reset, `req=4'b0010`, `ch_id="GBB"`, min=(12,34), max=(100,200), usedw=0 → writes "GBB", 0x000C0022, 0x006400C8 on the next three cycles; `ack[1]` with the third write.
- All four channels requesting continuously → grant order 0,1,2,3,0, exactly 4 cycles per message, no gaps in the pattern.
- usedw=253 with `req` high → no write. Drop usedw to 252 → message starts the next cycle.
- `flush` asserted in W_MIN → returns to IDLE, no `ack`. The same channel is re-served from its ID word.
- `enable=0` while a request is pending → no grant. Clearing `enable` during W_ID → message still completes.
- `reset_n` asserted asynchronously in W_MIN → `fifo_wrreq`, `ack` and `busy` go to 0 immediately. After release, channel 0 has first priority.

Source files
------------

// File: rtl/imgproc_pkg.sv
// imgproc_pkg: shared message-writer states, sizes and coordinate packing.
package imgproc_pkg;
  typedef enum logic [1:0] {IDLE, W_ID, W_MIN, W_MAX} state_t;
  localparam int MSG_WORDS = 3;
  localparam int COORD_W = 11;
  function automatic logic [31:0] pack_xy(input logic [2*COORD_W-1:0] p);
    return {5'b0, p[2*COORD_W-1:COORD_W], 5'b0, p[COORD_W-1:0]};
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority encoder, search starts at last+1 mod n.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   last,
  output logic         valid,
  output logic [2:0]   idx
);
  always_comb begin
    valid = 1'b0;
    idx = '0;
    for (int i = N; i >= 1; i--)
      if (req[(int'(last) + i) % N]) begin
        valid = 1'b1;
        idx = 3'((int'(last) + i) % N);
      end
  end
endmodule

// File: rtl/msg_arbiter.sv
// msg_arbiter: round-robin writer of three-word bounding-box messages into a shared FIFO.
module msg_arbiter
  import imgproc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int FIFO_DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [NUM_CH-1:0]     req,
  input  logic [NUM_CH*32-1:0]  ch_id,
  input  logic [NUM_CH*22-1:0]  ch_min,
  input  logic [NUM_CH*22-1:0]  ch_max,
  output logic [NUM_CH-1:0]     ack,
  input  logic [7:0]            fifo_usedw,
  output logic                  fifo_wrreq,
  output logic [31:0]           fifo_data,
  output logic                  busy,
  output logic [2:0]            grant_ch
);
  state_t state, next;
  logic [2:0] last, pick_idx;
  logic pick_valid, skip, start, served;
  logic [31:0] cap_id;
  logic [2*COORD_W-1:0] cap_min, cap_max;
  logic [NUM_CH-1:0] grant_oh, mask;
  assign grant_oh = NUM_CH'(1) << grant_ch;
  // requester may drop req one cycle after ack; mask it to avoid a double send
  assign mask = skip ? ~grant_oh : '1;
  rr_pick #(.N(NUM_CH)) u_pick (
    .req(req & mask),
    .last(last),
    .valid(pick_valid),
    .idx(pick_idx)
  );
  assign start = state == IDLE && enable && pick_valid && !flush &&
                 int'(fifo_usedw) <= FIFO_DEPTH - (MSG_WORDS + 1);
  assign served = state == W_MAX && !flush;
  always_comb
    next = flush ? IDLE :
           state == IDLE ? (start ? W_ID : IDLE) :
           state == W_ID ? W_MIN :
           state == W_MIN ? W_MAX : IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      last <= 3'(NUM_CH - 1);
      grant_ch <= '0;
      skip <= 1'b0;
      cap_id <= '0;
      cap_min <= '0;
      cap_max <= '0;
    end else begin
      state <= next;
      skip <= served;
      if (served) last <= grant_ch;
      if (start) begin
        grant_ch <= pick_idx;
        cap_id <= ch_id[32*int'(pick_idx) +: 32];
        cap_min <= ch_min[22*int'(pick_idx) +: 22];
        cap_max <= ch_max[22*int'(pick_idx) +: 22];
      end
    end
  assign ack = served ? grant_oh : '0;
  assign fifo_wrreq = state != IDLE;
  assign busy = state != IDLE;
  assign fifo_data = state == W_ID ? cap_id :
                     state == W_MIN ? pack_xy(cap_min) :
                     state == W_MAX ? pack_xy(cap_max) : '0;
endmodule

// File: tb/tb_msg_arbiter.sv
// tb_msg_arbiter: vector table plus directed flush, async-reset and round-robin sequences.
module tb_msg_arbiter;
  localparam logic [31:0] ID0 = 32'h00524242, ID1 = 32'h00474242;
  localparam logic [31:0] ID2 = 32'h00424242, ID3 = 32'h00594242;
  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b1, flush = 1'b0;
  logic [3:0] req = '0, ack;
  logic [127:0] ch_id;
  logic [87:0] ch_min, ch_max;
  logic [7:0] fifo_usedw = '0;
  logic fifo_wrreq, busy;
  logic [31:0] fifo_data;
  logic [2:0] grant_ch;
  int checks = 0, failures = 0;

  msg_arbiter #(.NUM_CH(4), .FIFO_DEPTH(256)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush), .req(req),
    .ch_id(ch_id), .ch_min(ch_min), .ch_max(ch_max), .ack(ack),
    .fifo_usedw(fifo_usedw), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
    .busy(busy), .grant_ch(grant_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req; logic [7:0] usedw; logic en;
    logic wr; logic [31:0] data; logic [3:0] ack; logic busy; logic [2:0] grant;
  } vec_t;
  vec_t tv[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0; req = '0; flush = 1'b0; enable = 1'b1; fifo_usedw = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    ch_id = {ID3, ID2, ID1, ID0};
    ch_min = {11'd9, 11'd10, 11'd5, 11'd6, 11'd12, 11'd34, 11'd1, 11'd2};
    ch_max = {11'd11, 11'd12, 11'd7, 11'd8, 11'd100, 11'd200, 11'd3, 11'd4};
    tv[0]  = '{4'b0010, 8'd0,   1'b1, 1'b0, 32'h0,        4'b0000, 1'b0, 3'd0};
    tv[1]  = '{4'b0010, 8'd0,   1'b1, 1'b1, ID1,          4'b0000, 1'b1, 3'd1};
    tv[2]  = '{4'b0010, 8'd0,   1'b1, 1'b1, 32'h000C0022, 4'b0000, 1'b1, 3'd1};
    tv[3]  = '{4'b0010, 8'd0,   1'b1, 1'b1, 32'h006400C8, 4'b0010, 1'b1, 3'd1};
    tv[4]  = '{4'b0010, 8'd0,   1'b1, 1'b0, 32'h0,        4'b0000, 1'b0, 3'd1};
    tv[5]  = '{4'b0000, 8'd0,   1'b1, 1'b0, 32'h0,        4'b0000, 1'b0, 3'd1};
    tv[6]  = '{4'b0001, 8'd253, 1'b1, 1'b0, 32'h0,        4'b0000, 1'b0, 3'd1};
    tv[7]  = '{4'b0001, 8'd253, 1'b1, 1'b0, 32'h0,        4'b0000, 1'b0, 3'd1};
    tv[8]  = '{4'b0001, 8'd252, 1'b1, 1'b0, 32'h0,        4'b0000, 1'b0, 3'd1};
    tv[9]  = '{4'b0001, 8'd252, 1'b1, 1'b1, ID0,          4'b0000, 1'b1, 3'd0};
    tv[10] = '{4'b0001, 8'd0,   1'b1, 1'b1, 32'h00010002, 4'b0000, 1'b1, 3'd0};
    tv[11] = '{4'b0001, 8'd0,   1'b1, 1'b1, 32'h00030004, 4'b0001, 1'b1, 3'd0};
    tv[12] = '{4'b0000, 8'd0,   1'b1, 1'b0, 32'h0,        4'b0000, 1'b0, 3'd0};
    tv[13] = '{4'b0100, 8'd0,   1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 3'd0};
    tv[14] = '{4'b0100, 8'd0,   1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 3'd0};
    tv[15] = '{4'b0100, 8'd0,   1'b1, 1'b0, 32'h0,        4'b0000, 1'b0, 3'd0};
    tv[16] = '{4'b0100, 8'd0,   1'b0, 1'b1, ID2,          4'b0000, 1'b1, 3'd2};
    tv[17] = '{4'b0100, 8'd0,   1'b0, 1'b1, 32'h00050006, 4'b0000, 1'b1, 3'd2};
    tv[18] = '{4'b0100, 8'd0,   1'b0, 1'b1, 32'h00070008, 4'b0100, 1'b1, 3'd2};
    tv[19] = '{4'b0000, 8'd0,   1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 3'd2};
    do_reset();
    for (int i = 0; i < 20; i++) begin
      req = tv[i].req; fifo_usedw = tv[i].usedw; enable = tv[i].en;
      #1;
      chk($sformatf("v%0d wrreq", i), 32'(fifo_wrreq), 32'(tv[i].wr));
      chk($sformatf("v%0d data", i), fifo_data, tv[i].data);
      chk($sformatf("v%0d ack", i), 32'(ack), 32'(tv[i].ack));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(tv[i].busy));
      chk($sformatf("v%0d grant", i), 32'(grant_ch), 32'(tv[i].grant));
      tick();
    end
    // flush during W_MIN, then full retry of the same channel
    enable = 1'b1; req = 4'b0010;
    tick();
    chk("fl id", fifo_data, ID1);
    tick();
    flush = 1'b1;
    #1;
    chk("fl ack", 32'(ack), 32'h0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl idle busy", 32'(busy), 32'h0);
    chk("fl idle wr", 32'(fifo_wrreq), 32'h0);
    tick();
    chk("fl retry id", fifo_data, ID1);
    chk("fl retry grant", 32'(grant_ch), 32'd1);
    tick();
    chk("fl retry min", fifo_data, 32'h000C0022);
    tick();
    chk("fl retry ack", 32'(ack), 32'b0010);
    req = '0;
    tick();
    // async reset in W_MIN, then channel 0 first
    req = 4'b0100;
    tick();
    chk("rs grant", 32'(grant_ch), 32'd2);
    tick();
    chk("rs wmin", fifo_data, 32'h00050006);
    #2 reset_n = 1'b0;
    #1;
    chk("rs wrreq", 32'(fifo_wrreq), 32'h0);
    chk("rs ack", 32'(ack), 32'h0);
    chk("rs busy", 32'(busy), 32'h0);
    chk("rs grant0", 32'(grant_ch), 32'h0);
    @(negedge clk);
    reset_n = 1'b1; req = 4'b1111;
    tick();
    chk("rs first grant", 32'(grant_ch), 32'd0);
    chk("rs first id", fifo_data, ID0);
    // all channels continuously: 0,1,2,3,0 every 4 cycles
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk($sformatf("rr%0d ack", k), 32'(ack), (k % 4 == 3) ? 32'(1) << ((k / 4) % 4) : 32'h0);
      chk($sformatf("rr%0d wrreq", k), 32'(fifo_wrreq), 32'(k % 4 != 0));
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
